// File: rtl/gps_cfg_pkg.sv
// Shared constants and types for the GPS generator SPI configuration block.
package gps_cfg_pkg;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_SAT      = 3'd1;
   localparam logic [2:0] ADDR_CA_PHASE = 3'd2;
   localparam logic [2:0] ADDR_DOPPLER  = 3'd3;
   localparam logic [2:0] ADDR_SNR      = 3'd4;
   localparam logic [2:0] ADDR_ID       = 3'd5;
   localparam logic [2:0] ADDR_STATUS   = 3'd6;
   localparam logic [2:0] ADDR_COMMIT   = 3'd7;

   localparam int FRAME_LEN = 24;
   localparam int HDR_LEN   = 8;

   localparam int CTRL_ENA        = 0;
   localparam int CTRL_USE_PRESET = 1;
   localparam int CTRL_PRESET_LO  = 2;
   localparam int CTRL_PRESET_HI  = 3;
   localparam int CTRL_USE_MSG    = 4;
   localparam int CTRL_NOISE_OFF  = 5;
   localparam int CTRL_SIGNAL_OFF = 6;

   localparam int CA_MAX_DEF = 16367;

   typedef struct packed {
      logic [6:0]  ctrl;
      logic [4:0]  n_sat;
      logic [15:0] ca_phase;
      logic [7:0]  doppler;
      logic [7:0]  snr;
   } cfg_t;

   localparam cfg_t CFG_RESET = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } frame_st_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin with rise/fall detection in the clk_in domain.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst_in_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign q    = sync_r[SYNC_STAGES-1];
   assign rise = q & ~prev_r;
   assign fall = ~q & prev_r;

endmodule

// File: rtl/gps_cfg_spi.sv
// SPI-slave configuration front end for gps_gen_core: shadow registers,
// atomic COMMIT into the active set, and MISO read-back of active values.
//
// Frame state table:
//   state    | meaning
//   ST_IDLE  | no frame open (cs_n high or never seen falling)
//   ST_SHIFT | frame open, capturing bits on sclk rising edges
//   ST_DONE  | 24 bits captured, further sclk edges ignored for capture
module gps_cfg_spi
   import gps_cfg_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          CA_MAX      = CA_MAX_DEF,
   parameter logic [15:0] ID_VALUE    = 16'hC0DE
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        sclk_in,
   input  logic        cs_n_in,
   input  logic        mosi_in,
   output logic        miso_out,
   output logic        ena_out,
   output logic [4:0]  n_sat_out,
   output logic        use_preset_out,
   output logic [1:0]  preset_sel_out,
   output logic        use_msg_preset_out,
   output logic        noise_off_out,
   output logic        signal_off_out,
   output logic [15:0] ca_phase_out,
   output logic [7:0]  doppler_out,
   output logic [7:0]  snr_out,
   output logic        cfg_update_out,
   output logic        err_out
);

   localparam logic [15:0] CA_MAX_W = 16'(CA_MAX);

   logic sclk_q, sclk_rise, sclk_fall;
   logic cs_q, cs_rise, cs_fall;
   logic mosi_q, mosi_rise, mosi_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .d(sclk_in),
      .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .d(cs_n_in),
      .q(cs_q), .rise(cs_rise), .fall(cs_fall));

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .d(mosi_in),
      .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));

   frame_st_t   state;
   logic [4:0]  bit_cnt;
   logic [23:0] shift_in;
   logic [23:0] shift_nxt;
   logic [15:0] shift_out;
   logic [15:0] rd_value;
   logic        rd_act;
   logic        miso_r;
   logic        frame_done;
   logic        rd_stat_clr;

   cfg_t        shadow;
   cfg_t        active;
   logic        pending;
   logic        err_r;
   logic        cfg_update_r;

   logic        unused_ok;
   assign unused_ok = &{1'b0, sclk_q, cs_q, mosi_rise, mosi_fall, shift_in[22:19]};

   assign shift_nxt = {shift_in[22:0], mosi_q};

   // Read-back value for the address carried in the header being completed
   always_comb begin
      rd_value = '0;
      case (shift_nxt[2:0])
         ADDR_CTRL:     rd_value = {9'd0, active.ctrl};
         ADDR_SAT:      rd_value = {11'd0, active.n_sat};
         ADDR_CA_PHASE: rd_value = active.ca_phase;
         ADDR_DOPPLER:  rd_value = {8'd0, active.doppler};
         ADDR_SNR:      rd_value = {8'd0, active.snr};
         ADDR_ID:       rd_value = ID_VALUE;
         ADDR_STATUS:   rd_value = {14'd0, pending, err_r};
         default:       rd_value = '0;
      endcase
   end

   // Frame tracking, bit capture and MISO shift-out
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift_in    <= '0;
         shift_out   <= '0;
         rd_act      <= 1'b0;
         miso_r      <= 1'b0;
         frame_done  <= 1'b0;
         rd_stat_clr <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         rd_stat_clr <= 1'b0;
         if (cs_fall) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            rd_act  <= 1'b0;
            miso_r  <= 1'b0;
         end else if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rd_act  <= 1'b0;
            miso_r  <= 1'b0;
         end else if (state != ST_IDLE) begin
            if (state == ST_SHIFT && sclk_rise) begin
               shift_in <= shift_nxt;
               bit_cnt  <= bit_cnt + 5'd1;
               // Header complete: latch the active value now so later commits cannot tear it
               if (bit_cnt == 5'(HDR_LEN - 1) && shift_nxt[7]) begin
                  shift_out   <= rd_value;
                  rd_act      <= 1'b1;
                  rd_stat_clr <= (shift_nxt[2:0] == ADDR_STATUS);
               end
               if (bit_cnt == 5'(FRAME_LEN - 1)) begin
                  state      <= ST_DONE;
                  frame_done <= 1'b1;
               end
            end
            if (sclk_fall) begin
               miso_r    <= rd_act & shift_out[15];
               shift_out <= {shift_out[14:0], 1'b0};
            end
         end
      end
   end

   // Shadow writes, commit into active set, pending/err status
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         shadow       <= CFG_RESET;
         active       <= CFG_RESET;
         pending      <= 1'b0;
         err_r        <= 1'b0;
         cfg_update_r <= 1'b0;
      end else begin
         cfg_update_r <= 1'b0;
         if (rd_stat_clr) begin
            err_r <= 1'b0;
         end
         if (frame_done && !shift_in[23]) begin
            case (shift_in[18:16])
               ADDR_CTRL: begin
                  shadow.ctrl <= shift_in[6:0];
                  pending     <= 1'b1;
               end
               ADDR_SAT: begin
                  shadow.n_sat <= shift_in[4:0];
                  pending      <= 1'b1;
               end
               ADDR_CA_PHASE: begin
                  if (shift_in[15:0] > CA_MAX_W) begin
                     err_r <= 1'b1;
                  end else begin
                     shadow.ca_phase <= shift_in[15:0];
                     pending         <= 1'b1;
                  end
               end
               ADDR_DOPPLER: begin
                  shadow.doppler <= shift_in[7:0];
                  pending        <= 1'b1;
               end
               ADDR_SNR: begin
                  shadow.snr <= shift_in[7:0];
                  pending    <= 1'b1;
               end
               ADDR_COMMIT: begin
                  active       <= shadow;
                  cfg_update_r <= 1'b1;
                  pending      <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign miso_out           = miso_r;
   assign ena_out            = active.ctrl[CTRL_ENA];
   assign use_preset_out     = active.ctrl[CTRL_USE_PRESET];
   assign preset_sel_out     = active.ctrl[CTRL_PRESET_HI:CTRL_PRESET_LO];
   assign use_msg_preset_out = active.ctrl[CTRL_USE_MSG];
   assign noise_off_out      = active.ctrl[CTRL_NOISE_OFF];
   assign signal_off_out     = active.ctrl[CTRL_SIGNAL_OFF];
   assign n_sat_out          = active.n_sat;
   assign ca_phase_out       = active.ca_phase;
   assign doppler_out        = active.doppler;
   assign snr_out            = active.snr;
   assign cfg_update_out     = cfg_update_r;
   assign err_out            = err_r;

endmodule

// File: tb/tb_gps_cfg_spi.sv
// Self-checking bench for gps_cfg_spi: directed scenarios plus random frames
// against an address-indexed register model.
module tb_gps_cfg_spi;

   localparam int CA_MAX = 16367;
   localparam int unsigned MASK [5] = '{32'h7F, 32'h1F, 32'hFFFF, 32'hFF, 32'hFF};

   logic        clk_in = 1'b0;
   logic        rst_in_n;
   logic        sclk_in;
   logic        cs_n_in;
   logic        mosi_in;
   logic        miso_out;
   logic        ena_out;
   logic [4:0]  n_sat_out;
   logic        use_preset_out;
   logic [1:0]  preset_sel_out;
   logic        use_msg_preset_out;
   logic        noise_off_out;
   logic        signal_off_out;
   logic [15:0] ca_phase_out;
   logic [7:0]  doppler_out;
   logic [7:0]  snr_out;
   logic        cfg_update_out;
   logic        err_out;

   logic [43:0] dut_outs;

   int errors  = 0;
   int checks  = 0;
   int upd_cnt = 0;

   int unsigned m_sh  [5];
   int unsigned m_act [5];
   bit          m_pend;
   bit          m_err;

   gps_cfg_spi dut (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
      .mosi_in(mosi_in), .miso_out(miso_out), .ena_out(ena_out), .n_sat_out(n_sat_out),
      .use_preset_out(use_preset_out), .preset_sel_out(preset_sel_out),
      .use_msg_preset_out(use_msg_preset_out), .noise_off_out(noise_off_out),
      .signal_off_out(signal_off_out), .ca_phase_out(ca_phase_out),
      .doppler_out(doppler_out), .snr_out(snr_out), .cfg_update_out(cfg_update_out),
      .err_out(err_out));

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) if (cfg_update_out) upd_cnt++;

   assign dut_outs = {ena_out, n_sat_out, use_preset_out, preset_sel_out, use_msg_preset_out,
                      noise_off_out, signal_off_out, ca_phase_out, doppler_out, snr_out};

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) begin
         m_sh[i]  = 0;
         m_act[i] = 0;
      end
      m_pend = 1'b0;
      m_err  = 1'b0;
   endfunction

   function automatic logic [15:0] model_rd(input int addr);
      if (addr < 5)  return 16'(m_act[addr]);
      if (addr == 5) return 16'hC0DE;
      if (addr == 6) return {14'd0, m_pend, m_err};
      return 16'h0000;
   endfunction

   function automatic void model_wr(input int addr, input logic [15:0] data);
      if (addr < 5) begin
         if (addr == 2 && int'(data) > CA_MAX) begin
            m_err = 1'b1;
         end else begin
            m_sh[addr] = int'(data) & MASK[addr];
            m_pend     = 1'b1;
         end
      end else if (addr == 7) begin
         m_act  = m_sh;
         m_pend = 1'b0;
      end
   endfunction

   function automatic logic [43:0] exp_outs();
      logic [6:0] c;
      c = 7'(m_act[0]);
      return {c[0], 5'(m_act[1]), c[1], c[3:2], c[4], c[5], c[6],
              16'(m_act[2]), 8'(m_act[3]), 8'(m_act[4])};
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // SPI mode-0 master at clk_in/4; miso sampled at the end of each high phase
   task automatic spi_xfer(input logic [23:0] tx, input int nbits, input bit end_cs,
                           output logic [15:0] rx);
      logic [23:0] rx_full;
      rx_full = '0;
      cs_n_in = 1'b0;
      wait_clk(2);
      for (int i = 0; i < nbits; i++) begin
         mosi_in = tx[23-i];
         wait_clk(2);
         sclk_in = 1'b1;
         wait_clk(2);
         rx_full[23-i] = miso_out;
         sclk_in = 1'b0;
      end
      mosi_in = 1'b0;
      if (end_cs) begin
         wait_clk(2);
         cs_n_in = 1'b1;
         wait_clk(4);
      end
      rx = rx_full[15:0];
   endtask

   task automatic test_reset();
      logic [15:0] rx;
      rst_in_n = 1'b0;
      sclk_in  = 1'b0;
      cs_n_in  = 1'b1;
      mosi_in  = 1'b0;
      model_reset();
      wait_clk(4);
      rst_in_n = 1'b1;
      wait_clk(4);
      checks++;
      if (dut_outs !== 44'h0) $display("FAIL reset_outs: got %h expected 0", dut_outs);
      if (dut_outs !== 44'h0) errors++;
      checks++;
      if ({miso_out, cfg_update_out, err_out} !== 3'b000) begin
         $display("FAIL reset_flags: got %b expected 000", {miso_out, cfg_update_out, err_out});
         errors++;
      end
      spi_xfer(24'h850000, 24, 1'b1, rx);
      checks++;
      if (rx !== 16'hC0DE) begin
         $display("FAIL id_read: got %h expected c0de", rx);
         errors++;
      end
   endtask

   task automatic test_commit();
      logic [15:0] rx;
      logic [7:0]  dop_prev, snr_prev, dop_at, snr_at;
      bit          seen, width_ok;
      int          cnt0;
      spi_xfer(24'h03002A, 24, 1'b1, rx); model_wr(3, 16'h002A);
      spi_xfer(24'h040003, 24, 1'b1, rx); model_wr(4, 16'h0003);
      checks++;
      if ({doppler_out, snr_out} !== 16'h0000) begin
         $display("FAIL precommit_outs: got %h expected 0000", {doppler_out, snr_out});
         errors++;
      end
      spi_xfer(24'h860000, 24, 1'b1, rx);
      checks++;
      if (rx !== 16'h0002) begin
         $display("FAIL status_pending: got %h expected 0002", rx);
         errors++;
      end
      cnt0 = upd_cnt; seen = 1'b0; width_ok = 1'b0;
      dop_prev = doppler_out; snr_prev = snr_out;
      fork
         spi_xfer(24'h070000, 24, 1'b1, rx);
         begin
            for (int c = 0; c < 300 && !seen; c++) begin
               @(negedge clk_in);
               if (cfg_update_out) begin
                  seen = 1'b1; dop_at = doppler_out; snr_at = snr_out;
               end else begin
                  dop_prev = doppler_out; snr_prev = snr_out;
               end
            end
            @(negedge clk_in);
            width_ok = !cfg_update_out;
         end
      join
      model_wr(7, 16'h0);
      checks++;
      if (!seen) begin
         $display("FAIL commit_pulse: got no cfg_update_out within 300 cycles expected one");
         errors++;
      end else begin
         checks++;
         if ({dop_at, snr_at} !== 16'h2A03 || {dop_prev, snr_prev} !== 16'h0000) begin
            $display("FAIL commit_atomic: got before %h at %h expected 0000 then 2a03",
                     {dop_prev, snr_prev}, {dop_at, snr_at});
            errors++;
         end
      end
      checks++;
      if (!width_ok || upd_cnt - cnt0 != 1) begin
         $display("FAIL commit_width: got %0d pulses width_ok=%0d expected 1 single-cycle",
                  upd_cnt - cnt0, width_ok);
         errors++;
      end
      spi_xfer(24'h860000, 24, 1'b1, rx);
      checks++;
      if (rx !== 16'h0000) begin
         $display("FAIL status_clear: got %h expected 0000", rx);
         errors++;
      end
   endtask

   task automatic test_ca_limit();
      logic [15:0] rx;
      spi_xfer(24'h023FEF, 24, 1'b1, rx); model_wr(2, 16'h3FEF);
      spi_xfer(24'h070000, 24, 1'b1, rx); model_wr(7, 16'h0);
      checks++;
      if (ca_phase_out !== 16'd16367 || err_out !== 1'b0) begin
         $display("FAIL ca_max_ok: got ca %0d err %b expected 16367 err 0", ca_phase_out, err_out);
         errors++;
      end
      spi_xfer(24'h023FF0, 24, 1'b1, rx); model_wr(2, 16'h3FF0);
      checks++;
      if (err_out !== 1'b1) begin
         $display("FAIL ca_over_err: got %b expected 1", err_out);
         errors++;
      end
      spi_xfer(24'h070000, 24, 1'b1, rx); model_wr(7, 16'h0);
      checks++;
      if (ca_phase_out !== 16'd16367) begin
         $display("FAIL ca_shadow_kept: got %0d expected 16367", ca_phase_out);
         errors++;
      end
      spi_xfer(24'h860000, 24, 1'b1, rx);
      checks++;
      if (rx !== 16'h0001) begin
         $display("FAIL status_err: got %h expected 0001", rx);
         errors++;
      end
      m_err = 1'b0;
      checks++;
      if (err_out !== 1'b0) begin
         $display("FAIL err_clear: got %b expected 0", err_out);
         errors++;
      end
   endtask

   task automatic test_abort();
      logic [15:0] rx;
      spi_xfer(24'h00007F, 12, 1'b1, rx);
      spi_xfer(24'h070000, 24, 1'b1, rx); model_wr(7, 16'h0);
      checks++;
      if ({ena_out, use_preset_out, preset_sel_out, use_msg_preset_out, noise_off_out,
           signal_off_out} !== 7'h00) begin
         $display("FAIL abort_ctrl: got ena %b preset %b sel %b msg %b noise %b sig %b expected all 0",
                  ena_out, use_preset_out, preset_sel_out, use_msg_preset_out,
                  noise_off_out, signal_off_out);
         errors++;
      end
      checks++;
      if (dut_outs !== exp_outs()) begin
         $display("FAIL abort_outs: got %h expected %h", dut_outs, exp_outs());
         errors++;
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rx;
      spi_xfer(24'h01001F, 14, 1'b0, rx);
      rst_in_n = 1'b0;
      #2;
      checks++;
      if (dut_outs !== 44'h0 || miso_out !== 1'b0 || err_out !== 1'b0) begin
         $display("FAIL midreset_outs: got %h miso %b err %b expected all 0",
                  dut_outs, miso_out, err_out);
         errors++;
      end
      cs_n_in = 1'b1;
      sclk_in = 1'b0;
      model_reset();
      wait_clk(3);
      rst_in_n = 1'b1;
      wait_clk(4);
      spi_xfer(24'h070000, 24, 1'b1, rx); model_wr(7, 16'h0);
      checks++;
      if (n_sat_out !== 5'd0 || dut_outs !== 44'h0) begin
         $display("FAIL midreset_commit: got n_sat %h outs %h expected 0", n_sat_out, dut_outs);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rx, data, exp_rd;
      logic [23:0] frame;
      int          addr, cnt0, commits;
      bit          rw;
      cnt0    = upd_cnt;
      commits = 0;
      for (int n = 0; n < 60; n++) begin
         addr = int'($urandom_range(0, 7));
         rw   = ($urandom_range(0, 2) == 0);
         if (addr == 2 && $urandom_range(0, 1) == 1)
            data = 16'($urandom_range(0, CA_MAX));
         else
            data = 16'($urandom);
         frame  = {rw, 4'($urandom), 3'(addr), data};
         exp_rd = model_rd(addr);
         spi_xfer(frame, 24, 1'b1, rx);
         wait_clk($urandom_range(0, 3));
         if (rw) begin
            if (addr == 6) m_err = 1'b0;
            checks++;
            if (rx !== exp_rd) begin
               $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", n, addr, rx, exp_rd);
               errors++;
            end
         end else begin
            model_wr(addr, data);
            if (addr == 7) begin
               commits++;
               checks++;
               if (dut_outs !== exp_outs()) begin
                  $display("FAIL rand_commit[%0d]: got %h expected %h", n, dut_outs, exp_outs());
                  errors++;
               end
            end
         end
         checks++;
         if (err_out !== m_err) begin
            $display("FAIL rand_err[%0d]: got %b expected %b", n, err_out, m_err);
            errors++;
         end
      end
      checks++;
      if (upd_cnt - cnt0 != commits) begin
         $display("FAIL rand_update_count: got %0d expected %0d", upd_cnt - cnt0, commits);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_ca_limit();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
